trail_scheduler: RTL

TRAIL_SCHEDULER -- requirements
Module: trail_scheduler

---
 rtl/trail_scheduler.sv | 98 +++++++++
 1 files changed

// File: rtl/trail_scheduler.sv
// trail_scheduler: ring of drifting, decaying trail particles spawned behind the player once every SPAWN_DIV run frames.
// Optional build macro TRAIL_JITTER_EN adds an 8-bit LFSR that jitters each spawn y by -2..+1 pixels.
module trail_scheduler #(
  parameter int NUM_TRAIL   = 41,
  parameter int PLAYER_X    = 160,
  parameter int PLAYER_SIZE = 40,
  parameter int LIFE_MAX    = 10,
  parameter int DRIFT       = 2,
  parameter int SPAWN_DIV   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame_tick,
  input  logic [1:0]                 gamemode,
  input  logic [8:0]                 player_y,
  output logic [NUM_TRAIL-1:0][9:0]  trail_x,
  output logic [NUM_TRAIL-1:0][8:0]  trail_y,
  output logic [NUM_TRAIL-1:0][3:0]  trail_life,
  output logic [5:0]                 active_count
);
  localparam int HW = NUM_TRAIL > 1 ? $clog2(NUM_TRAIL) : 1;
  localparam logic [9:0] DR = 10'(DRIFT);
  localparam logic [9:0] PX = 10'(PLAYER_X);
  localparam logic [8:0] HALF = 9'(PLAYER_SIZE / 2);
  localparam logic [3:0] LM = 4'(LIFE_MAX);
  localparam logic [3:0] DIV_LAST = 4'(SPAWN_DIV - 1);
  localparam logic [HW-1:0] LAST = HW'(NUM_TRAIL - 1);
  logic [HW-1:0] head, head_n;
  logic [3:0] div, div_n;
  logic [NUM_TRAIL-1:0][9:0] x_n;
  logic [NUM_TRAIL-1:0][8:0] y_n;
  logic [NUM_TRAIL-1:0][3:0] l_n;
  logic [5:0] cnt_n;
  logic [8:0] spawn_y;
  logic spawn;
`ifdef TRAIL_JITTER_EN
  logic [7:0] lfsr;
  assign spawn_y = player_y + HALF + {7'b0, lfsr[1:0]} - 9'd2;
  // Jitter source steps once per spawn so each particle gets a fresh offset.
  always_ff @(posedge clk)
    if (rst) lfsr <= 8'hA5;
    else if (spawn) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
`else
  assign spawn_y = player_y + HALF;
`endif
  // Next slot contents: START clears, RUN/OVER ticks decay and drift, RUN alone spawns into head.
  always_comb begin
    x_n = trail_x;
    y_n = trail_y;
    l_n = trail_life;
    head_n = head;
    div_n = div;
    spawn = 1'b0;
    cnt_n = '0;
    if (gamemode == 2'b00) begin
      x_n = '0;
      y_n = '0;
      l_n = '0;
      head_n = '0;
      div_n = '0;
    end else if (frame_tick && gamemode[0]) begin
      for (int i = 0; i < NUM_TRAIL; i++)
        if (trail_life[i] != 4'd0) begin
          l_n[i] = trail_x[i] < DR ? 4'd0 : trail_life[i] - 4'd1;
          x_n[i] = trail_x[i] < DR ? trail_x[i] : trail_x[i] - DR;
        end
      if (!gamemode[1]) begin
        spawn = div == DIV_LAST;
        div_n = spawn ? 4'd0 : div + 4'd1;
        if (spawn) begin
          x_n[head] = PX;
          y_n[head] = spawn_y;
          l_n[head] = LM;
          head_n = head == LAST ? '0 : head + 1'b1;
        end
      end
    end
    for (int i = 0; i < NUM_TRAIL; i++)
      cnt_n = cnt_n + {5'b0, |l_n[i]};
  end
  // Register slots, ring pointer, divider and the live count together so they always agree.
  always_ff @(posedge clk)
    if (rst) begin
      trail_x <= '0;
      trail_y <= '0;
      trail_life <= '0;
      active_count <= '0;
      head <= '0;
      div <= '0;
    end else begin
      trail_x <= x_n;
      trail_y <= y_n;
      trail_life <= l_n;
      active_count <= cnt_n;
      head <= head_n;
      div <= div_n;
    end
endmodule
